// File: rtl/vga_fb_arbiter.sv
// Shares a single-port synchronous-read pixel RAM between VGA scan-out (priority) and a
// queued host write port. Pixels appear a fixed two clocks after the scan position.
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        column,
    input  logic [9:0]        row,
    input  logic              rgb_en,
    input  logic              host_wr_valid,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [2:0]        fifo_level,
    output logic              wr_addr_err
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] HMul = H_ACTIVE;
    localparam logic [9:0] HActive = 10'(H_ACTIVE);
    localparam logic [9:0] VActive = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] PixCount = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StDispRd, StHostWr} grant_e;

    grant_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_pend_q;
    logic [DATA_W-1:0] pix_data_q;
    logic              pix_valid_q;
    logic              err_q;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic              fifo_oor_q  [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;

    logic              disp_req;
    logic              full;
    logic              push;
    logic              pop;
    logic              push_oor;
    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] pix_addr;

    assign disp_req      = rgb_en && (column < HActive) && (row < VActive);
    assign full          = (count_q == Depth);
    assign host_wr_ready = !full && !rst;
    assign push          = host_wr_valid && host_wr_ready;
    assign push_oor      = (host_wr_addr >= PixCount);
    assign row_ext       = {{(ADDR_W - 10){1'b0}}, row};

    // Constant multiply by H_ACTIVE as a sum of shifted rows (640 -> row<<9 + row<<7).
    always_comb begin
        pix_addr = {{(ADDR_W - 10){1'b0}}, column};
        for (int i = 0; i < 32; i++) begin
            if (HMul[i]) begin
                pix_addr = pix_addr + (row_ext << i);
            end
        end
    end

    // Grant decision; count_q excludes this cycle's push, so there is no bypass path.
    always_comb begin
        state_d     = StIdle;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        if (disp_req) begin
            state_d    = StDispRd;
            mem_addr_d = pix_addr;
        end else if (count_q != '0) begin
            state_d = StHostWr;
            pop     = 1'b1;
            // Out-of-range entries are consumed without touching the RAM bus.
            if (!fifo_oor_q[rd_ptr_q]) begin
                mem_addr_d  = fifo_addr_q[rd_ptr_q];
                mem_wdata_d = fifo_data_q[rd_ptr_q];
                mem_we_d    = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= host_wr_addr;
            fifo_data_q[wr_ptr_q] <= host_wr_data;
            fifo_oor_q[wr_ptr_q]  <= push_oor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            // RAM captures mem_addr one edge after the grant; its data is sampled the next edge.
            rd_pend_q   <= (state_q == StDispRd);
            pix_valid_q <= rd_pend_q;
            pix_data_q  <= rd_pend_q ? mem_rdata : '0;
            if (push && push_oor) begin
                err_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign fifo_level  = 3'(count_q);
    assign wr_addr_err = err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: scan-out reads, host write queueing/drain, address
// errors and asynchronous reset, against a behavioural synchronous-read RAM.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  column;
    logic [9:0]  row;
    logic        rgb_en;
    logic        host_wr_valid;
    logic [18:0] host_wr_addr;
    logic [7:0]  host_wr_data;
    logic        host_wr_ready;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [2:0]  fifo_level;
    logic        wr_addr_err;

    logic [7:0]  ram [0:(1 << 19) - 1];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .ADDR_W    (19),
        .DATA_W    (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .column       (column),
        .row          (row),
        .rgb_en       (rgb_en),
        .host_wr_valid(host_wr_valid),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_ready(host_wr_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .fifo_level   (fifo_level),
        .wr_addr_err  (wr_addr_err)
    );

    // Single-port RAM, read-before-write, one-clock read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < (1 << 19); a++) ram[a] = 8'(a * 37 + 11);
        rst = 1'b1;
        column = '0;
        row = '0;
        rgb_en = 1'b0;
        host_wr_valid = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        #2;
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_ready", 32'(host_wr_ready), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(host_wr_ready), 1);

        // Scan-out reads: row 1 col 0, then last pixel.
        rgb_en = 1'b1;
        row = 10'd1;
        column = 10'd0;
        tick();
        chk("rd0_addr", 32'(mem_addr), 640);
        chk("rd0_we", 32'(mem_we), 0);
        chk("rd0_pix_valid_early", 32'(pix_valid), 0);
        row = 10'd479;
        column = 10'd639;
        tick();
        chk("rd1_addr", 32'(mem_addr), 307199);
        chk("rd1_pix_valid_early", 32'(pix_valid), 0);
        rgb_en = 1'b0;
        tick();
        chk("rd0_pix", 32'(pix_data), 32'h8B);
        chk("rd0_valid", 32'(pix_valid), 1);
        tick();
        chk("rd1_pix", 32'(pix_data), 32'hE6);
        chk("rd1_valid", 32'(pix_valid), 1);
        tick();
        chk("blank_pix", 32'(pix_data), 0);
        chk("blank_valid", 32'(pix_valid), 0);

        // Single host write in blanking.
        host_wr_valid = 1'b1;
        host_wr_addr = 19'd5;
        host_wr_data = 8'hA5;
        tick();
        host_wr_valid = 1'b0;
        chk("hw_level1", 32'(fifo_level), 1);
        chk("hw_no_bypass", 32'(mem_we), 0);
        tick();
        chk("hw_we", 32'(mem_we), 1);
        chk("hw_addr", 32'(mem_addr), 5);
        chk("hw_data", 32'(mem_wdata), 32'hA5);
        chk("hw_level0", 32'(fifo_level), 0);
        tick();
        chk("hw_we_one_cycle", 32'(mem_we), 0);

        // Fill FIFO during active video; fifth push is refused.
        rgb_en = 1'b1;
        row = 10'd10;
        column = 10'd20;
        for (int i = 0; i < 5; i++) begin
            host_wr_valid = 1'b1;
            host_wr_addr = 19'(100 + i);
            host_wr_data = 8'(16 + i);
            #1;
            chk($sformatf("fill_ready_%0d", i), 32'(host_wr_ready), (i < 4) ? 1 : 0);
            tick();
            chk($sformatf("fill_we_%0d", i), 32'(mem_we), 0);
        end
        host_wr_valid = 1'b0;
        chk("fill_level", 32'(fifo_level), 4);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("stall_we_%0d", i), 32'(mem_we), 0);
        end
        chk("stall_level", 32'(fifo_level), 4);
        chk("stall_addr", 32'(mem_addr), 10 * 640 + 20);
        rgb_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain_we_%0d", i), 32'(mem_we), 1);
            chk($sformatf("drain_addr_%0d", i), 32'(mem_addr), 100 + i);
            chk($sformatf("drain_data_%0d", i), 32'(mem_wdata), 16 + i);
            chk($sformatf("drain_level_%0d", i), 32'(fifo_level), 3 - i);
        end
        tick();
        chk("drain_done_we", 32'(mem_we), 0);
        chk("ram_written_103", 32'(ram[103]), 32'h13);

        // Out-of-range host address.
        host_wr_valid = 1'b1;
        host_wr_addr = 19'd307200;
        host_wr_data = 8'h77;
        tick();
        host_wr_valid = 1'b0;
        chk("oor_err_set", 32'(wr_addr_err), 1);
        chk("oor_level", 32'(fifo_level), 1);
        tick();
        chk("oor_dropped_we", 32'(mem_we), 0);
        chk("oor_popped", 32'(fifo_level), 0);
        host_wr_valid = 1'b1;
        host_wr_addr = 19'd7;
        host_wr_data = 8'h3C;
        tick();
        host_wr_valid = 1'b0;
        tick();
        chk("post_oor_we", 32'(mem_we), 1);
        chk("post_oor_addr", 32'(mem_addr), 7);
        chk("err_sticky", 32'(wr_addr_err), 1);

        // Three writes queued behind active video, then async reset mid-frame.
        rgb_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_wr_valid = 1'b1;
            host_wr_addr = 19'(200 + i);
            host_wr_data = 8'(32 + i);
            tick();
        end
        host_wr_valid = 1'b0;
        chk("q3_level", 32'(fifo_level), 3);
        chk("q3_pix_valid", 32'(pix_valid), 1);
        rst = 1'b1;
        #2;
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_ready", 32'(host_wr_ready), 0);
        chk("mid_rst_err", 32'(wr_addr_err), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_pix_valid", 32'(pix_valid), 0);
        chk("mid_rst_pix_data", 32'(pix_data), 0);
        rgb_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_we_%0d", i), 32'(mem_we), 0);
            chk($sformatf("post_rst_valid_%0d", i), 32'(pix_valid), 0);
        end
        chk("post_rst_level", 32'(fifo_level), 0);
        host_wr_valid = 1'b1;
        host_wr_addr = 19'd9;
        host_wr_data = 8'h99;
        tick();
        host_wr_valid = 1'b0;
        tick();
        chk("new_push_we", 32'(mem_we), 1);
        chk("new_push_addr", 32'(mem_addr), 9);
        chk("new_push_data", 32'(mem_wdata), 32'h99);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
